// File: rtl/gearbox_tx_pkg.sv
// Shared PCS constants and types for the 66b->64b transmit gearbox.
package gearbox_tx_pkg;

  localparam int HEAD_W     = 2;
  localparam int DATA_W     = 64;
  localparam int BLOCK_W    = HEAD_W + DATA_W;
  localparam int GB_SEQ_MAX = 32;
  localparam int SEQ_W      = $clog2(GB_SEQ_MAX + 1);

  typedef logic [SEQ_W-1:0] seq_t;

endpackage

// File: rtl/gearbox_lane_tx.sv
// One lane of the transmit gearbox: residual register plus shift/select.
// At sequence k the residual holds HEAD_W*k valid bits; the incoming block
// is placed directly above them and the low DATA_W bits leave as a word.
module gearbox_lane_tx #(
  parameter int HEAD_W = gearbox_tx_pkg::HEAD_W,
  parameter int DATA_W = gearbox_tx_pkg::DATA_W,
  parameter int SEQ_W  = gearbox_tx_pkg::SEQ_W
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              load,
  input  logic              flush,
  input  logic [SEQ_W-1:0]  seq,
  input  logic [HEAD_W-1:0] head,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] word
);
  import gearbox_tx_pkg::*;

  logic [DATA_W-1:0]   residual;
  logic [DATA_W-1:0]   mask;
  logic [2*DATA_W-1:0] ext;
  int unsigned         shift_amt;

  // Place the block above the valid residual bits; the top of the block never
  // exceeds bit 2*DATA_W-1 for any sequence value that accepts a block.
  always_comb begin
    shift_amt = int'(seq) * HEAD_W;
    mask      = ~({DATA_W{1'b1}} << shift_amt);
    ext       = ({{(DATA_W-HEAD_W){1'b0}}, data, head} << shift_amt)
              | {{DATA_W{1'b0}}, residual & mask};
  end

  // Output word and residual update: flush drains a full residual word.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      residual <= '0;
      word     <= '0;
    end else if (flush) begin
      word     <= residual;
      residual <= '0;
    end else if (load) begin
      word     <= ext[DATA_W-1:0];
      residual <= ext[2*DATA_W-1:DATA_W];
    end
  end

endmodule

// File: rtl/gearbox_tx.sv
// Multi-lane 66b->64b transmit gearbox: shared sequence counter and
// handshake, one gearbox_lane_tx per lane.
module gearbox_tx #(
  parameter int LANE_N = 4,
  parameter int HEAD_W = gearbox_tx_pkg::HEAD_W,
  parameter int DATA_W = gearbox_tx_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     valid_i,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  input  logic [LANE_N*DATA_W-1:0] data_i,
  output logic                     ready_o,
  output logic                     valid_o,
  output logic [LANE_N*DATA_W-1:0] data_o
);
  import gearbox_tx_pkg::*;

  seq_t seq;
  logic accept;
  logic flush;

  assign ready_o = (seq != seq_t'(GB_SEQ_MAX));
  assign flush   = ~ready_o;
  assign accept  = valid_i & ready_o;

  // Sequence counter and output-valid flag shared by all lanes.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      seq     <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= accept | flush;
      if (flush)       seq <= '0;
      else if (accept) seq <= seq + 1'b1;
    end
  end

  for (genvar g = 0; g < LANE_N; g++) begin : g_lane
    gearbox_lane_tx #(
      .HEAD_W (HEAD_W),
      .DATA_W (DATA_W),
      .SEQ_W  (SEQ_W)
    ) u_lane (
      .clk    (clk),
      .nreset (nreset),
      .load   (accept),
      .flush  (flush),
      .seq    (seq),
      .head   (head_i[g*HEAD_W +: HEAD_W]),
      .data   (data_i[g*DATA_W +: DATA_W]),
      .word   (data_o[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: doc/gearbox_tx.md
GEARBOX_TX -- requirements
Module: gearbox_tx

Interface
REQ-001 SHALL have parameter LANE_N, default 4, number of PCS lanes.
REQ-002 SHALL have parameter HEAD_W, default 2, sync header width per lane.
REQ-003 SHALL have parameter DATA_W, default 64, block payload width per lane and output word width per lane.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port nreset, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port valid_i, input, 1, all lanes present a 66-bit block this cycle.
REQ-007 SHALL have port head_i, input, LANE_N*HEAD_W, sync headers from alignment-marker insertion; lane i occupies bits [i*HEAD_W +: HEAD_W].
REQ-008 SHALL have port data_i, input, LANE_N*DATA_W, block payloads; lane i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port ready_o, output, 1, gearbox accepts a block this cycle.
REQ-010 SHALL have port valid_o, output, 1, data_o holds a valid 64-bit word for every lane.
REQ-011 SHALL have port data_o, output, LANE_N*DATA_W, 64-bit PMA words; lane i occupies bits [i*DATA_W +: DATA_W].

Function
REQ-012 SHALL form each lane's 66-bit block as {data, head}, with head[0] at block bit 0 and transmitted first.
REQ-013 SHALL keep one shared sequence counter seq in the range 0..32, common to all lanes.
REQ-014 SHALL drive ready_o = (seq != 32), combinationally from seq only.
REQ-015 SHALL define the accept condition as valid_i & ready_o.
REQ-016 SHALL, for each lane on accept at seq = k (0..31):
- form {block, residual}, where residual is 2k bits;
- register its low 64 bits into data_o;
- keep the upper 2k+2 bits as the new residual;
- increment seq.
REQ-017 SHALL, at seq = 32:
- register the 64-bit residual into data_o regardless of valid_i;
- clear the residual to 0 bits;
- set seq to 0;
- leave head_i/data_i unconsumed.
REQ-018 SHALL, when seq < 32 and accept is low, hold seq and residual, deassert valid_o next cycle, and hold data_o.
REQ-019 SHALL assert valid_o one cycle after every accept and one cycle after every seq = 32 cycle.
REQ-020 SHALL have a latency of 1 clock from an accepted block to its first bits appearing on data_o.
REQ-021 SHALL, under continuous valid_i, produce 33 output words per 32 accepted blocks, with ready_o low exactly one cycle in 33.
REQ-022 SHALL preserve bit order exactly: concatenating the data_o words LSB-first reproduces the concatenated 66-bit block stream.
REQ-023 SHALL not alter header or payload content, including alignment-marker blocks.

Reset
REQ-024 SHALL, while nreset = 0, asynchronously set seq = 0, residual = 0, valid_o = 0 and data_o = 0; ready_o = 1 follows combinationally from seq = 0.
REQ-025 SHALL, on reset assertion mid-sequence, discard the residual bits, and SHALL restart at seq = 0 with the first accepted block after release.

Structure
REQ-026 SHALL place HEAD_W, DATA_W, BLOCK_W (= HEAD_W + DATA_W) and GB_SEQ_MAX (= 32) in the shared PCS package.
REQ-027 SHALL instantiate one sub-module per lane, gearbox_lane_tx, which holds the residual register and the shift/select logic; the top holds seq, ready_o and valid_o.
REQ-028 SHALL implement the residual as a 64-bit register per lane plus a 2k-bit select, with no wider than 130-bit intermediate.

Verification
REQ-029 SHALL verify reset release then continuous valid_i with block j = {data = j, head = 2'b01} -> ready_o low on cycles 32, 65, 98; 66 valid words; LSB-first bitstream equals the 64 concatenated blocks.
REQ-030 SHALL verify the first accepted block {data = 64'hFFFF_FFFF_FFFF_FFFF, head = 2'b10} -> next-cycle data_o lane 0 = 64'hFFFF_FFFF_FFFF_FFFE, residual = 2'b11.
REQ-031 SHALL verify valid_i dropped for 3 cycles at seq = 10 -> valid_o low for 3 cycles, seq stays 10, and the stream resumes with no bit lost.
REQ-032 SHALL verify valid_i = 0 at seq = 32 -> residual word still emitted with valid_o = 1, and seq wraps to 0.
REQ-033 SHALL verify nreset pulsed low at seq = 20 -> valid_o = 0, data_o = 0 and ready_o = 1 immediately; after release, the output matches a fresh-start reference model.
REQ-034 SHALL verify 4 lanes with distinct marker-pattern blocks (lane 0 low bytes 90 76 47) -> each lane's output is independent and correctly ordered, with no cross-lane bit leakage.
